// File: rtl/decode_shape.sv
// rtl/decode_shape.sv - recovers shape code and leftmost column from a two-row piece bitmap
module decode_shape #(
    parameter int WIDTH = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:WIDTH] line1,
    input  logic [1:WIDTH] line2,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2:0]     out_shape,
    output logic [3:0]     out_col,
    output logic           out_match,
    output logic           out_empty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_MATCH,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

    state_t         state_q, state_d;
    logic [1:WIDTH] r1_q, r1_d;
    logic [1:WIDTH] r2_q, r2_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           empty_q, empty_d;
    logic           out_valid_q, out_valid_d;
    logic [2:0]     out_shape_q, out_shape_d;
    logic [3:0]     out_col_q, out_col_d;
    logic           out_match_q, out_match_d;
    logic           out_empty_q, out_empty_d;

    logic [2:0]     code;
    logic           tail;

    // Window classifier: anything to the right of column 4 makes the bitmap illegal.
    always_comb begin
        tail = 1'b0;
        for (int i = 5; i <= WIDTH; i++) begin
            tail = tail | r1_q[i] | r2_q[i];
        end
        case ({r1_q[1:4], r2_q[1:4]})
            8'b1100_1100: code = 3'd1;
            8'b1110_0100: code = 3'd2;
            8'b0110_1100: code = 3'd3;
            8'b1100_0110: code = 3'd4;
            8'b0010_1110: code = 3'd5;
            8'b1000_1110: code = 3'd6;
            8'b0000_1111: code = 3'd7;
            default:      code = 3'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        cnt_d       = cnt_q;
        empty_d     = empty_q;
        out_valid_d = out_valid_q;
        out_shape_d = out_shape_q;
        out_col_d   = out_col_q;
        out_match_d = out_match_q;
        out_empty_d = out_empty_q;
        in_ready    = (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r1_d    = line1;
                    r2_d    = line2;
                    cnt_d   = 4'd0;
                    empty_d = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r1_q[1] | r2_q[1]) begin
                    state_d = S_MATCH;
                end else if (cnt_q == CNT_LAST) begin
                    empty_d = 1'b1;
                    state_d = S_MATCH;
                end else begin
                    r1_d  = {r1_q[2:WIDTH], 1'b0};
                    r2_d  = {r2_q[2:WIDTH], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_MATCH: begin
                out_valid_d = 1'b1;
                state_d     = S_DONE;
                if (empty_q) begin
                    out_shape_d = 3'd0;
                    out_col_d   = 4'd0;
                    out_match_d = 1'b0;
                    out_empty_d = 1'b1;
                end else begin
                    out_col_d   = cnt_q + 4'd1;
                    out_empty_d = 1'b0;
                    if (!tail && code != 3'd0) begin
                        out_shape_d = code;
                        out_match_d = 1'b1;
                    end else begin
                        out_shape_d = 3'd0;
                        out_match_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            cnt_q       <= 4'd0;
            empty_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_shape_q <= 3'd0;
            out_col_q   <= 4'd0;
            out_match_q <= 1'b0;
            out_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            cnt_q       <= cnt_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_shape_q <= out_shape_d;
            out_col_q   <= out_col_d;
            out_match_q <= out_match_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_shape = out_shape_q;
    assign out_col   = out_col_q;
    assign out_match = out_match_q;
    assign out_empty = out_empty_q;

endmodule

// File: doc/decode_shape.md
Name: decode_shape

Overview:
- Inverse of the spawn-shape generator: accepts a two-row, 10-column piece bitmap (line1 = upper row, line2 = lower row) and recovers the 3-bit shape code (1..7) and the leftmost occupied column.
- Used by the hold/swap and recolour logic to identify whatever piece currently occupies the two-row window.
- Sequential scanner: shifts the rows left until column 1 is occupied, then matches a 4-column normalized window against the seven piece patterns.

Parameters:
WIDTH, 10, board columns per row; bit 1 is the leftmost column; must be >= 4.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
line1  input  [1:WIDTH]  upper row bitmap; column 1 = MSB
line2  input  [1:WIDTH]  lower row bitmap
in_valid  input  1  line1/line2 valid
in_ready  output  1  decoder idle and able to accept
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts result
out_shape  output  3  decoded shape code 1..7; 0 = none
out_col  output  4  leftmost occupied column 1..WIDTH; 0 if empty
out_match  output  1  window matched a legal shape
out_empty  output  1  both rows all zero

Behaviour:
- Reset: state IDLE; out_valid, out_shape, out_col, out_match, out_empty = 0; shift registers and counter = 0. Reset wins over every other event, including mid-SCAN and DONE; in_ready = 1 the cycle after reset.
- in_ready = 1 only in IDLE; decoded combinationally from state.
- IDLE:
  - in_valid & in_ready: capture line1/line2 into shift regs r1/r2, set counter = 0, go to SCAN.
  - in_valid in any other state is ignored; the input is not captured.
- SCAN: evaluated once per cycle.
  - If r1[1] | r2[1]: go to MATCH; no shift that cycle.
  - Else if counter == WIDTH-1: go to MATCH with the empty flag set.
  - Else shift r1 and r2 left by one with zero fill, and counter++.
  - For leftmost occupied column c, SCAN lasts c cycles. For empty rows, SCAN lasts WIDTH cycles.
- MATCH (1 cycle):
  - Register the results, out_valid <= 1, go to DONE.
  - out_col = counter+1 if not empty, else 0.
  - A pattern is legal only if r1[5:WIDTH] and r2[5:WIDTH] are all zero.
  - Windows r1[1:4] / r2[1:4]:
    - 1: 1100/1100
    - 2: 1110/0100
    - 3: 0110/1100
    - 4: 1100/0110
    - 5: 0010/1110
    - 6: 1000/1110
    - 7: 0000/1111
  - Legal match: out_shape = code, out_match = 1.
  - Otherwise: out_shape = 0, out_match = 0.
  - Empty: out_shape = 0, out_match = 0, out_empty = 1.
- DONE:
  - Outputs are held stable while out_ready = 0.
  - out_valid & out_ready: out_valid <= 0, go to IDLE. Result outputs keep their values until the next MATCH.
  - A new input can be accepted in the cycle after the handshake.
- Latency: out_valid rises c+1 cycles after the accepting edge (WIDTH+1 if empty).
- Shapes clipped at the right edge (e.g. a T with c = 9) fail matching by construction; this is legal behaviour, not an error.

Test Plan:
- O at spawn: line1 = line2 = 0000110000 -> out_shape = 1, out_col = 5, out_match = 1; out_valid 6 cycles after accept.
- T at left edge: line1 = 1110000000, line2 = 0100000000 -> out_shape = 2, out_col = 1, latency 2. Repeat all seven generator spawn outputs -> codes 1..7, out_col = 5 for code 1, 4 for codes 2..7.
- Shifted I: line1 = 0, line2 = 0000001111 -> out_shape = 7, out_col = 7, out_match = 1.
- Empty rows: both 0 -> out_empty = 1, out_shape = 0, out_col = 0, out_match = 0; latency 11.
- Illegal bitmap: line1 = 1000000001, line2 = 0 -> out_match = 0, out_shape = 0, out_col = 1.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, a pulsed in_valid is not captured.
  - out_ready = 1 -> IDLE; back-to-back input accepted the next cycle.
  - reset asserted mid-SCAN -> all outputs 0 and in_ready = 1 the cycle after reset.
